// File: rtl/tff_pkg.sv
// Shared types and default constants for the toggle debouncer.
package tff_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int CNT_W_DEF           = 4;

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } tff_state_e;

endpackage

// File: rtl/tff_sync.sv
// Two-flop synchroniser bringing the raw button level into the clk domain.
module tff_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/tff_toggle_debouncer.sv
// Push-button debouncer emitting a one-cycle toggle strobe per accepted press,
// plus the debounced level and a wrapping press counter.
module tff_toggle_debouncer
  import tff_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             btn_in,
  output logic             t_pulse,
  output logic             btn_level,
  output logic [CNT_W-1:0] press_cnt,
  output logic             busy
);

  localparam logic [7:0]       DB_MAX  = 8'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic sync;

  tff_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (sync)
  );

  tff_state_e       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             t_pulse_q, t_pulse_d;
  logic             btn_level_q, btn_level_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             accept_press;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_press = 1'b0;
    if (ena) begin
      unique case (state_q)
        ST_RELEASED: begin
          if (sync) begin
            state_d = ST_PRESS_CHK;
            cnt_d   = 8'd1;
          end
        end
        ST_PRESS_CHK: begin
          if (!sync) begin
            state_d = ST_RELEASED;
            cnt_d   = 8'd0;
          end else if (cnt_q < DB_MAX) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            state_d      = ST_PRESSED;
            cnt_d        = 8'd0;
            accept_press = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!sync) begin
            state_d = ST_RELEASE_CHK;
            cnt_d   = 8'd1;
          end
        end
        ST_RELEASE_CHK: begin
          if (sync) begin
            state_d = ST_PRESSED;
            cnt_d   = 8'd0;
          end else if (cnt_q < DB_MAX) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            state_d = ST_RELEASED;
            cnt_d   = 8'd0;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = 8'd0;
        end
      endcase
    end

    // Outputs are registered from the next state so they move on the accepting edge.
    t_pulse_d   = accept_press;
    press_cnt_d = accept_press ? press_cnt_q + CNT_ONE : press_cnt_q;
    btn_level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_CHK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RELEASED;
      cnt_q       <= 8'd0;
      t_pulse_q   <= 1'b0;
      btn_level_q <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_pulse_q   <= t_pulse_d;
      btn_level_q <= btn_level_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign t_pulse   = t_pulse_q;
  assign btn_level = btn_level_q;
  assign press_cnt = press_cnt_q;
  assign busy      = (state_q == ST_PRESS_CHK) || (state_q == ST_RELEASE_CHK);

endmodule
